turn_lamp_monitor: RTL

Receive-side checker for the six-lamp turn-signal bus driven by the tail-light sequencer. It samples the lamp pattern on a strobe and tracks the left or right sweep as a state machine. It reports current direction and phase, counts completed sweeps per side, and flags illegal patterns or illegal transitions. The block sits beside the sequencer in the lighting subsystem and is used for self-check and fault reporting.

---
 rtl/turn_lamp_monitor_if.sv | 8 +
 rtl/turn_lamp_monitor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/turn_lamp_monitor_if.sv
// Lamp bus between the tail-light sequencer and its receive-side monitor.
interface turn_lamp_monitor_if;
  logic       sample;
  logic [5:0] lamps;

  modport master (output sample, output lamps);
  modport slave  (input  sample, input  lamps);
endinterface

// File: rtl/turn_lamp_monitor.sv
// Receive-side checker for the six-lamp turn-signal bus: tracks the sweep,
// counts completed sweeps per side and reports illegal patterns/transitions.
module turn_lamp_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  turn_lamp_monitor_if.slave   bus,
  input  logic                 clr_err,
  output logic [1:0]           dir,
  output logic [1:0]           phase,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     left_count,
  output logic [CNT_W-1:0]     right_count
);

  typedef enum logic [2:0] {
    S_OFF, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3
  } state_t;

  state_t     state_q, state_d, decoded;
  logic       legal, step_ok;
  logic       err_pat, err_trans, inc_left, inc_right;
  logic [1:0] dir_d, phase_d;

  always_comb begin
    legal   = 1'b1;
    decoded = S_OFF;
    case (bus.lamps)
      6'b000000: decoded = S_OFF;
      6'b001000: decoded = S_L1;
      6'b011000: decoded = S_L2;
      6'b111000: decoded = S_L3;
      6'b000100: decoded = S_R1;
      6'b000110: decoded = S_R2;
      6'b000111: decoded = S_R3;
      default:   legal   = 1'b0;
    endcase
  end

  always_comb begin
    step_ok = 1'b0;
    case (state_q)
      S_OFF:       step_ok = (decoded == S_OFF) || (decoded == S_L1) || (decoded == S_R1);
      S_L1:        step_ok = (decoded == S_L2);
      S_L2:        step_ok = (decoded == S_L3);
      S_R1:        step_ok = (decoded == S_R2);
      S_R2:        step_ok = (decoded == S_R3);
      S_L3, S_R3:  step_ok = (decoded == S_OFF);
      default:     step_ok = 1'b0;
    endcase
  end

  // An illegal transition still resynchronises to the sampled pattern.
  always_comb begin
    state_d   = state_q;
    err_pat   = 1'b0;
    err_trans = 1'b0;
    inc_left  = 1'b0;
    inc_right = 1'b0;
    if (bus.sample) begin
      if (!legal) begin
        err_pat = 1'b1;
        state_d = S_OFF;
      end else begin
        state_d = decoded;
        if (!step_ok) begin
          err_trans = 1'b1;
        end else begin
          inc_left  = (state_q == S_L3);
          inc_right = (state_q == S_R3);
        end
      end
    end
  end

  always_comb begin
    dir_d   = 2'b00;
    phase_d = 2'd0;
    case (state_d)
      S_L1:    begin dir_d = 2'b01; phase_d = 2'd1; end
      S_L2:    begin dir_d = 2'b01; phase_d = 2'd2; end
      S_L3:    begin dir_d = 2'b01; phase_d = 2'd3; end
      S_R1:    begin dir_d = 2'b10; phase_d = 2'd1; end
      S_R2:    begin dir_d = 2'b10; phase_d = 2'd2; end
      S_R3:    begin dir_d = 2'b10; phase_d = 2'd3; end
      default: begin dir_d = 2'b00; phase_d = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OFF;
      dir         <= 2'b00;
      phase       <= 2'd0;
      err_pulse   <= 1'b0;
      err_code    <= 2'b00;
      err_sticky  <= 1'b0;
      left_count  <= '0;
      right_count <= '0;
    end else begin
      state_q   <= state_d;
      dir       <= dir_d;
      phase     <= phase_d;
      err_pulse <= err_pat | err_trans;
      if (err_pat) begin
        err_code <= 2'b01;
      end else if (err_trans) begin
        err_code <= 2'b10;
      end
      // A same-edge error overrides clr_err.
      if (err_pat || err_trans) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
      if (inc_left && (left_count != '1)) begin
        left_count <= left_count + 1'b1;
      end
      if (inc_right && (right_count != '1)) begin
        right_count <= right_count + 1'b1;
      end
    end
  end

endmodule
